// File: rtl/mux_scan.sv
// mux_scan: steps a 4:1 mux select through keys 0..3, captures the mux output at the end of each dwell
// and presents the assembled 4-bit word on a valid/ready handshake. Optional macro: MUX_SCAN_CHANGE_EN adds `change`.
module mux_scan #(
    parameter int DWELL = 4,
    parameter int CW    = (DWELL > 1) ? $clog2(DWELL) : 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       cont,
    output logic [1:0] sel_out,
    input  logic       mux_in,
    output logic [3:0] sample,
    output logic       sample_valid,
    input  logic       sample_ready,
`ifdef MUX_SCAN_CHANGE_EN
    output logic       change,
`endif
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [3:0]    shreg;
    logic [1:0]    sel;
    logic          dwell_done;
    logic          accept;
    logic          scan_done;

    // Handshake: a word transfers on any rising edge with sample_valid && sample_ready.
    // sample_valid is a register (never a function of sample_ready); sample holds while it waits.
    assign dwell_done = (cnt == CNT_LAST);
    assign accept     = sample_valid && sample_ready;
    assign scan_done  = (state == SCAN) && dwell_done && (sel == 2'd3);
    assign sel_out    = sel;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SCAN;
            SCAN:    if (dwell_done && sel == 2'd3) state_nxt = HOLD;
            HOLD:    if (accept) state_nxt = cont ? SCAN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            shreg        <= '0;
            sel          <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt   <= '0;
                        sel   <= '0;
                        shreg <= '0;
                    end
                end
                SCAN: begin
                    if (!dwell_done) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        shreg[sel] <= mux_in;
                        cnt        <= '0;
                        if (sel != 2'd3) begin
                            sel <= sel + 2'd1;
                        end else begin
                            // Last slot goes straight into the result; shreg[3] is not yet updated here.
                            sample       <= {mux_in, shreg[2:0]};
                            sample_valid <= 1'b1;
                            sel          <= '0;
                        end
                    end
                end
                HOLD: begin
                    if (accept) begin
                        sample_valid <= 1'b0;
                        cnt          <= '0;
                        sel          <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MUX_SCAN_CHANGE_EN
    logic [3:0] last_acc;

    // Compare the new word against the last one downstream actually accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            change   <= 1'b0;
            last_acc <= '0;
        end else begin
            change <= scan_done && ({mux_in, shreg[2:0]} != last_acc);
            if (accept) last_acc <= sample;
        end
    end
`endif

endmodule
